// File: rtl/dm_access.sv
// Load/store access controller in front of the word-addressed data memory.
// Sub-word stores are done as read-modify-write because dm writes whole words.
module dm_access #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dm_mem_read,
  output logic              dm_mem_write,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_write_data,
  input  logic [31:0]       dm_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_err;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;
  logic [31:0]       st_merge;

  assign req_err = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (|req_addr[1:0]));

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    ld_byte  = dm_read_data[7:0];
    st_merge = dm_read_data;
    unique case (addr_q[1:0])
      2'd0: ld_byte = dm_read_data[7:0];
      2'd1: ld_byte = dm_read_data[15:8];
      2'd2: ld_byte = dm_read_data[23:16];
      default: ld_byte = dm_read_data[31:24];
    endcase
    ld_half = addr_q[1] ? dm_read_data[31:16] : dm_read_data[15:0];
    unique case (size_q)
      2'b00: ld_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
      2'b01: ld_ext = {{16{sign_q & ld_half[15]}}, ld_half};
      default: ld_ext = dm_read_data;
    endcase
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'd0: st_merge[7:0]   = wdata_q[7:0];
        2'd1: st_merge[15:8]  = wdata_q[7:0];
        2'd2: st_merge[23:16] = wdata_q[7:0];
        default: st_merge[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      st_merge[31:16] = wdata_q;
    end else begin
      st_merge[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    size_d        = size_q;
    sign_d        = sign_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    word_d        = word_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = 32'h0;
    resp_err      = 1'b0;
    dm_mem_read   = 1'b0;
    dm_mem_write  = 1'b0;
    dm_addr       = '0;
    dm_write_data = 32'h0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          sign_d  = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata[15:0];
          rdata_d = 32'h0;
          err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else if (req_write && req_size == 2'b10) begin
            word_d  = req_wdata;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        dm_mem_read = 1'b1;
        dm_addr     = addr_q[ADDR_W+1:2];
        if (write_q) begin
          word_d  = st_merge;
          state_d = WRITE;
        end else begin
          rdata_d = ld_ext;
          state_d = RESP;
        end
      end
      WRITE: begin
        dm_mem_write  = 1'b1;
        dm_addr       = addr_q[ADDR_W+1:2];
        dm_write_data = word_q;
        state_d       = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dm_access.sv
// Bench for dm_access: directed vector table, hand-written corner sequences
// and random requests checked against a byte-array memory model.
module tb_dm_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_mem_read;
  logic        dm_mem_write;
  logic [3:0]  dm_addr;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;

  logic [31:0] dm [16];
  logic [7:0]  mb [64];

  int checks = 0;
  int errors = 0;

  dm_access #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write),
    .dm_addr(dm_addr), .dm_write_data(dm_write_data),
    .dm_read_data(dm_read_data)
  );

  always #5 clk = ~clk;

  assign dm_read_data = dm[dm_addr];

  always @(posedge clk)
    if (dm_mem_write) dm[dm_addr] <= dm_write_data;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ref_err(input logic [1:0] sz, input logic [5:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
           (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [5:0] a);
    logic [5:0] b;
    b = {a[5:2], 2'b00};
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz,
                                           input logic sg,
                                           input logic [5:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[a + 6'(i)]) << (8 * i));
    if (sg && v[8*n-1]) for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz,
                        input logic sg, input logic [5:0] a,
                        input logic [31:0] wd, input logic [31:0] erd,
                        input logic eerr, input int elat,
                        input int erdn, input int ewrn,
                        input logic [31:0] eww);
    int lat, rdn, wrn, busy_rdy, both;
    logic got;
    logic [31:0] wword;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 1);
    req_valid = 1; req_write = w; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 0;
    req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = 6'($urandom);
    req_wdata = $urandom;
    if (w && !ref_err(sz, a))
      for (int i = 0; i < nbytes(sz); i++) mb[a + 6'(i)] = wd[8*i +: 8];
    lat = 1; rdn = 0; wrn = 0; busy_rdy = 0; both = 0;
    got = 0; wword = 0;
    while (lat <= 8) begin
      if (resp_valid) begin
        got = 1;
        break;
      end
      if (req_ready) busy_rdy++;
      if (dm_mem_read && dm_mem_write) both++;
      if (dm_mem_read) begin
        rdn++;
        chk("rd_addr", 32'(dm_addr), 32'(a[5:2]));
      end
      if (dm_mem_write) begin
        wrn++;
        wword = dm_write_data;
        chk("wr_addr", 32'(dm_addr), 32'(a[5:2]));
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk("resp_seen", 32'(got), 1);
    if (got) begin
      chk("latency", 32'(lat), 32'(elat));
      chk("rdata", resp_rdata, erd);
      chk("err", 32'(resp_err), 32'(eerr));
      chk("ready_in_resp", 32'(req_ready), 0);
    end
    chk("ready_busy", 32'(busy_rdy), 0);
    chk("rd_wr_same", 32'(both), 0);
    chk("rd_cycles", 32'(rdn), 32'(erdn));
    chk("wr_cycles", 32'(wrn), 32'(ewrn));
    if (ewrn != 0) chk("wr_data", wword, eww);
    @(posedge clk);
    #1;
    chk("resp_pulse", 32'(resp_valid), 0);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [5:0]  a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
    int          elat;
    int          erdn;
    int          ewrn;
    logic [31:0] eww;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [1:0]  sz;
    logic        w, sg, e;
    logic [5:0]  a;
    logic [31:0] wd, erd, eww;
    int          lat, rdn, wrn, seen;

    tbl[0]  = '{1, 2'd2, 0, 6'h08, 32'hDEADBEEF, 0, 0, 2, 0, 1, 32'hDEADBEEF};
    tbl[1]  = '{0, 2'd2, 0, 6'h08, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0, 0};
    tbl[2]  = '{1, 2'd0, 0, 6'h09, 32'h000000A5, 0, 0, 3, 1, 1, 32'hDEADA5EF};
    tbl[3]  = '{0, 2'd0, 1, 6'h09, 32'h0, 32'hFFFFFFA5, 0, 2, 1, 0, 0};
    tbl[4]  = '{0, 2'd0, 0, 6'h09, 32'h0, 32'h000000A5, 0, 2, 1, 0, 0};
    tbl[5]  = '{0, 2'd1, 1, 6'h0A, 32'h0, 32'hFFFFDEAD, 0, 2, 1, 0, 0};
    tbl[6]  = '{0, 2'd1, 0, 6'h08, 32'h0, 32'h0000A5EF, 0, 2, 1, 0, 0};
    tbl[7]  = '{0, 2'd2, 0, 6'h06, 32'h0, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{1, 2'd1, 0, 6'h03, 32'h1234, 0, 1, 1, 0, 0, 0};
    tbl[9]  = '{0, 2'd3, 1, 6'h00, 32'h0, 0, 1, 1, 0, 0, 0};
    tbl[10] = '{1, 2'd2, 0, 6'h04, 32'h11223344, 0, 0, 2, 0, 1, 32'h11223344};
    tbl[11] = '{0, 2'd1, 0, 6'h06, 32'h0, 32'h00001122, 0, 2, 1, 0, 0};

    for (int i = 0; i < 16; i++) dm[i] = 32'h0;
    for (int i = 0; i < 64; i++) mb[i] = 8'h0;
    rst = 1; req_valid = 0; req_write = 0; req_size = 0;
    req_signed = 0; req_addr = 0; req_wdata = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_dm_rd", 32'(dm_mem_read), 0);
    chk("rst_dm_wr", 32'(dm_mem_write), 0);
    chk("rst_dm_addr", 32'(dm_addr), 0);
    chk("rst_dm_wdata", dm_write_data, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 12; i++)
      do_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
             tbl[i].erd, tbl[i].eerr, tbl[i].elat, tbl[i].erdn,
             tbl[i].ewrn, tbl[i].eww);

    // Reset during the WRITE cycle of a half store to word 1
    @(negedge clk);
    req_valid = 1; req_write = 1; req_size = 2'd1;
    req_signed = 0; req_addr = 6'h04; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1;
    req_valid = 0;
    chk("abort_read", 32'(dm_mem_read), 1);
    @(posedge clk);
    #1;
    chk("abort_write_on", 32'(dm_mem_write), 1);
    #2 rst = 1;
    #1;
    chk("abort_write_drop", 32'(dm_mem_write), 0);
    chk("abort_read_off", 32'(dm_mem_read), 0);
    chk("abort_idle", 32'(req_ready), 1);
    chk("abort_no_resp", 32'(resp_valid), 0);
    @(posedge clk);
    #1;
    rst = 0;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    chk("abort_no_resp_after", 32'(seen), 0);
    chk("abort_word1", dm[1], 32'h11223344);

    // Two requests with valid held high throughout
    @(negedge clk);
    req_valid = 1; req_write = 0; req_size = 2'd2;
    req_signed = 0; req_addr = 6'h08;
    @(posedge clk);
    #1;
    chk("b2b_busy", 32'(req_ready), 0);
    req_size = 2'd0; req_addr = 6'h07;
    @(posedge clk);
    #1;
    chk("b2b_resp_a", 32'(resp_valid), 1);
    chk("b2b_data_a", resp_rdata, 32'hDEADA5EF);
    chk("b2b_ready_resp", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    chk("b2b_idle", 32'(req_ready), 1);
    chk("b2b_gap", 32'(resp_valid), 0);
    @(posedge clk);
    #1;
    chk("b2b_accept_b", 32'(req_ready), 0);
    req_valid = 0;
    @(posedge clk);
    #1;
    chk("b2b_resp_b", 32'(resp_valid), 1);
    chk("b2b_data_b", resp_rdata, 32'h00000011);
    @(posedge clk);
    #1;

    // Random traffic against the byte-array model
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      a  = 6'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 5) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
        if (sz == 2'd3) sz = 2'($urandom_range(0, 2));
        if (sz == 2'd2) a[1:0] = 2'b00;
        if (sz == 2'd1) a[0] = 1'b0;
      end
      e = ref_err(sz, a);
      erd = 0; eww = 0;
      if (e) begin
        lat = 1; rdn = 0; wrn = 0;
      end else if (!w) begin
        lat = 2; rdn = 1; wrn = 0;
        erd = ref_load(sz, sg, a);
      end else begin
        rdn = (sz == 2'd2) ? 0 : 1;
        wrn = 1;
        lat = (sz == 2'd2) ? 2 : 3;
        for (int i = 0; i < 64; i++) ;
        eww = ref_word(a);
        for (int i = 0; i < nbytes(sz); i++)
          eww[8*(int'(a[1:0]) + i) +: 8] = wd[8*i +: 8];
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(w, sz, sg, a, wd, erd, e, lat, rdn, wrn, eww);
    end

    for (int i = 0; i < 16; i++)
      chk("final_mem", dm[i], ref_word(6'(i * 4)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
